// File: rtl/latex_stream_engine_if.sv
// latex_stream_engine_if: bundle of control, lookup, ROM and stream signals for latex_stream_engine
//   master (engine side) drives ptr_line, mem_addr, ch_data, ch_valid, busy, done, err_line, err_ovf
//   slave (environment side) drives start, line, ptr_addr, mem_dout, ch_ready (and loop when enabled)
//   LATEX_STREAM_LOOP_EN adds the 1-bit loop input
interface latex_stream_engine_if #(
    parameter int NUM_CH = 2,
    parameter int CHAR_W = 8,
    parameter int PACK   = 2,
    parameter int ADDR_W = 10,
    parameter int LINE_W = 6
);
    logic                     start;
    logic [LINE_W-1:0]        line;
    logic [LINE_W-1:0]        ptr_line;
    logic [NUM_CH*ADDR_W-1:0] ptr_addr;
    logic [ADDR_W-1:0]        mem_addr;
    logic [PACK*CHAR_W-1:0]   mem_dout;
    logic [NUM_CH*CHAR_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH-1:0]        ch_ready;
    logic                     busy;
    logic                     done;
    logic                     err_line;
    logic [NUM_CH-1:0]        err_ovf;
`ifdef LATEX_STREAM_LOOP_EN
    logic                     loop;
`endif

    modport master (
        input  start, line, ptr_addr, mem_dout, ch_ready,
`ifdef LATEX_STREAM_LOOP_EN
        input  loop,
`endif
        output ptr_line, mem_addr, ch_data, ch_valid, busy, done, err_line, err_ovf
    );

    modport slave (
        output start, line, ptr_addr, mem_dout, ch_ready,
`ifdef LATEX_STREAM_LOOP_EN
        output loop,
`endif
        input  ptr_line, mem_addr, ch_data, ch_valid, busy, done, err_line, err_ovf
    );
endinterface

// File: rtl/latex_stream_engine.sv
// latex_stream_engine: streams NUM_CH terminated strings of a line from a packed character ROM
//   clk, rst_n           clock, asynchronous active-low reset
//   bus.start, bus.line  launch edge and line index
//   bus.ptr_line/ptr_addr  pointer-table lookup (per-channel start word address)
//   bus.mem_addr/mem_dout  ROM read port, data valid the cycle after mem_addr
//   bus.ch_data/ch_valid/ch_ready  per-channel character stream
//   bus.busy, bus.done, bus.err_line, bus.err_ovf  status
//   LATEX_STREAM_LOOP_EN: adds bus.loop, re-running the captured line from DONE
module latex_stream_engine #(
    parameter int               NUM_CH    = 2,
    parameter int               CHAR_W    = 8,
    parameter int               PACK      = 2,
    parameter int               ADDR_W    = 10,
    parameter int               LINE_W    = 6,
    parameter int               NUM_LINES = 51,
    parameter logic [CHAR_W-1:0] TERM     = '0
) (
    input logic                   clk,
    input logic                   rst_n,
    latex_stream_engine_if.master bus
);
    localparam int WW = PACK * CHAR_W;
    localparam int IW = PACK > 1 ? $clog2(PACK) : 1;
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam logic [LINE_W:0] NL = (LINE_W + 1)'(NUM_LINES);

    typedef enum logic [2:0] {IDLE, LOOK0, LOOK1, RUN, DONE} state_t;

    state_t state, state_n;
    logic start_q, launch, bad, finished, gnt_v, err_line_r;
    logic [LINE_W-1:0] ptr_line_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [ADDR_W-1:0] addr [NUM_CH];
    logic [WW-1:0] word [NUM_CH];
    logic [IW-1:0] idx [NUM_CH];
    logic [CHAR_W-1:0] cur [NUM_CH];
    logic [NUM_CH-1:0] full, pend, term, ovf, valid, fire, last_fire, at_term, elig;
    logic [NUM_CH*CHAR_W-1:0] data;
    logic [CW-1:0] last, gnt;

    assign launch   = bus.start && !start_q && (state == IDLE || state == DONE);
    assign bad      = {1'b0, bus.line} >= NL;
    assign finished = &term && !(|pend) && !(|full);

    // A channel may request its next word in the same cycle its last buffered
    // character is accepted, so a lone channel streams PACK chars every PACK+1 cycles.
    always_comb begin
        data = '0;
        valid = '0;
        fire = '0;
        last_fire = '0;
        at_term = '0;
        elig = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cur[c] = '0;
            for (int k = 0; k < PACK; k++)
                if (idx[c] == IW'(k)) cur[c] = word[c][WW-1-k*CHAR_W -: CHAR_W];
            valid[c] = full[c] && cur[c] != TERM;
            at_term[c] = full[c] && cur[c] == TERM;
            fire[c] = valid[c] && bus.ch_ready[c];
            last_fire[c] = fire[c] && idx[c] == IW'(PACK - 1);
            elig[c] = state == RUN && !term[c] && !pend[c] && (!full[c] || last_fire[c]);
            data[c*CHAR_W +: CHAR_W] = cur[c];
        end
    end

    // Round-robin: search begins one past the last granted channel.
    always_comb begin
        int j;
        gnt = last;
        gnt_v = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            j = int'(last) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!gnt_v && elig[j]) begin
                gnt_v = 1'b1;
                gnt = CW'(j);
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = launch ? (bad ? DONE : LOOK0) : IDLE;
            LOOK0:   state_n = LOOK1;
            LOOK1:   state_n = RUN;
            RUN:     state_n = finished ? DONE : RUN;
            DONE:    state_n = launch ? (bad ? DONE : LOOK0) :
`ifdef LATEX_STREAM_LOOP_EN
                               (bus.loop && !err_line_r) ? LOOK0 :
`endif
                               DONE;
            default: state_n = IDLE;
        endcase
    end

    // start_q resets high so a start held through reset is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            start_q <= 1'b1;
            ptr_line_r <= '0;
            mem_addr_r <= '0;
            err_line_r <= 1'b0;
            ovf <= '0;
            full <= '0;
            pend <= '0;
            term <= '0;
            last <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                addr[c] <= '0;
                word[c] <= '0;
                idx[c] <= '0;
            end
        end else begin
            state <= state_n;
            start_q <= bus.start;
            if (launch) begin
                ptr_line_r <= bus.line;
                err_line_r <= bad;
                ovf <= '0;
            end
            if (state == LOOK1) begin
                last <= CW'(NUM_CH - 1);
                full <= '0;
                pend <= '0;
                term <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    addr[c] <= bus.ptr_addr[c*ADDR_W +: ADDR_W];
                    idx[c] <= '0;
                end
            end else begin
                if (gnt_v) begin
                    mem_addr_r <= addr[gnt];
                    pend[gnt] <= 1'b1;
                    last <= gnt;
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    if (pend[c]) begin
                        word[c] <= bus.mem_dout;
                        full[c] <= 1'b1;
                        idx[c] <= '0;
                        pend[c] <= 1'b0;
                        addr[c] <= addr[c] + 1'b1;
                        // Wrapping past the top word stops further reads; the
                        // word just fetched still drains normally.
                        if (&addr[c]) begin
                            ovf[c] <= 1'b1;
                            term[c] <= 1'b1;
                        end
                    end else if (at_term[c]) begin
                        term[c] <= 1'b1;
                        full[c] <= 1'b0;
                    end else if (fire[c]) begin
                        full[c] <= !last_fire[c];
                        idx[c] <= last_fire[c] ? '0 : idx[c] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.ptr_line = ptr_line_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.ch_data  = data;
    assign bus.ch_valid = valid;
    assign bus.busy     = state == LOOK0 || state == LOOK1 || state == RUN;
    assign bus.done     = state == DONE;
    assign bus.err_line = err_line_r;
    assign bus.err_ovf  = ovf;
endmodule

// File: tb/tb_latex_stream_engine.sv
// tb_latex_stream_engine: scoreboard bench with pointer-table and ROM models for latex_stream_engine
module tb_latex_stream_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    latex_stream_engine_if bus ();
    latex_stream_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [15:0] rom [1024];
    logic [9:0] tab0 [64];
    logic [9:0] tab1 [64];
    logic [19:0] ptr_q;
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [1:0] hold_v = '0;
    logic [7:0] hold_d [2];
    logic [9:0] addr0;
    int n_chk = 0;
    int n_pass = 0;

    assign bus.mem_dout = rom[bus.mem_addr];
    assign bus.ptr_addr = ptr_q;
    always @(posedge clk) ptr_q <= {tab1[bus.ptr_line], tab0[bus.ptr_line]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string s0, input string s1);
        for (int i = 0; i < s0.len(); i++) q0.push_back(s0[i]);
        for (int i = 0; i < s1.len(); i++) q1.push_back(s1[i]);
    endtask

    task automatic pulse(input logic [5:0] l);
        bus.line = l;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!bus.done && n < 300) begin
            tick(1);
            n++;
        end
        check(tag, bus.done, 1);
    endtask

    task automatic run(input logic [5:0] l, input string s0, input string s1, input logic [1:0] ovf);
        push(s0, s1);
        pulse(l);
        check("busy_on_start", bus.busy, 1);
        wait_done("run_done");
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("err_flags", {bus.err_line, bus.err_ovf}, {1'b0, ovf});
        check("busy_after_done", bus.busy, 0);
    endtask

    // Scoreboard pop on every accepted character; stalled data must hold.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rst_n && hold_v[c])
                check(c == 0 ? "ch0_hold" : "ch1_hold", {bus.ch_valid[c], bus.ch_data[c*8 +: 8]}, {1'b1, hold_d[c]});
            if (rst_n && bus.ch_valid[c] && bus.ch_ready[c]) begin
                if (c == 0) begin
                    if (q0.size() == 0) check("ch0_extra", bus.ch_valid[0], 0);
                    else check("ch0_char", bus.ch_data[7:0], q0.pop_front());
                end else begin
                    if (q1.size() == 0) check("ch1_extra", bus.ch_valid[1], 0);
                    else check("ch1_char", bus.ch_data[15:8], q1.pop_front());
                end
            end
            hold_v[c] <= rst_n && bus.ch_valid[c] && !bus.ch_ready[c];
            hold_d[c] <= bus.ch_data[c*8 +: 8];
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = '0;
        for (int i = 0; i < 64; i++) begin
            tab0[i] = '0;
            tab1[i] = '0;
        end
        rom[100] = 16'h655e; rom[101] = 16'h7b2d; rom[102] = 16'h6174; rom[103] = 16'h7d00;
        rom[200] = 16'h5c66; rom[201] = 16'h7261; rom[202] = 16'h637b; rom[203] = 16'h317d;
        rom[204] = 16'h7b73; rom[205] = 16'h2b61; rom[206] = 16'h7d00;
        rom[300] = 16'h0041;
        rom[1022] = 16'h4142; rom[1023] = 16'h4344;
        tab0[3] = 10'd100; tab1[3] = 10'd200;
        tab0[4] = 10'd100; tab1[4] = 10'd1022;
        tab0[5] = 10'd300; tab1[5] = 10'd200;
        bus.start = 1'b1;
        bus.line = '0;
        bus.ch_ready = 2'b11;
`ifdef LATEX_STREAM_LOOP_EN
        bus.loop = 1'b0;
`endif
        tick(2);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_valid", bus.ch_valid, 0);
        check("rst_data", bus.ch_data, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_ptr_line", bus.ptr_line, 0);
        check("rst_err", {bus.err_line, bus.err_ovf}, 0);
        rst_n = 1'b1;
        tick(3);
        check("held_start_no_launch", bus.busy, 0);
        bus.start = 1'b0;
        tick(1);

        run(6'd3, "e^{-at}", "\\frac{1}{s+a}", 2'b00);
        tick(3);
        check("done_held", bus.done, 1);

        bus.ch_ready = 2'b10;
        push("e^{-at}", "\\frac{1}{s+a}");
        pulse(6'd3);
        tick(20);
        check("stall_valid", bus.ch_valid[0], 1);
        check("stall_data", bus.ch_data[7:0], 8'h65);
        tick(20);
        check("stall_ch1_complete", q1.size(), 0);
        check("stall_not_done", bus.done, 0);
        bus.ch_ready = 2'b11;
        wait_done("stall_done");
        check("stall_q0_drained", q0.size(), 0);

        addr0 = bus.mem_addr;
        pulse(6'd51);
        check("bad_done", bus.done, 1);
        check("bad_err_line", bus.err_line, 1);
        check("bad_busy", bus.busy, 0);
        tick(3);
        check("bad_mem_addr", bus.mem_addr, addr0);
        check("bad_valid", bus.ch_valid, 0);

        run(6'd4, "e^{-at}", "ABCD", 2'b10);
        run(6'd5, "", "\\frac{1}{s+a}", 2'b00);

        push("e^{-at}", "\\frac{1}{s+a}");
        pulse(6'd3);
        tick(6);
        pulse(6'd5);
        check("restart_ignored_busy", bus.busy, 1);
        wait_done("restart_done");
        check("restart_q0", q0.size(), 0);
        check("restart_q1", q1.size(), 0);
        tick(4);

        push("e^{-at}", "\\frac{1}{s+a}");
        pulse(6'd3);
        tick(8);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_valid", bus.ch_valid, 0);
        check("mid_rst_data", bus.ch_data, 0);
        check("mid_rst_mem_addr", bus.mem_addr, 0);
        check("mid_rst_ptr_line", bus.ptr_line, 0);
        q0.delete();
        q1.delete();
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_idle", {bus.busy, bus.done}, 0);
        run(6'd3, "e^{-at}", "\\frac{1}{s+a}", 2'b00);

`ifdef LATEX_STREAM_LOOP_EN
        bus.loop = 1'b1;
        push("e^{-at}e^{-at}e^{-at}", "\\frac{1}{s+a}\\frac{1}{s+a}\\frac{1}{s+a}");
        pulse(6'd3);
        wait_done("loop_pass1");
        tick(1);
        check("loop_pulse1", bus.done, 0);
        wait_done("loop_pass2");
        tick(1);
        check("loop_pulse2", bus.done, 0);
        bus.loop = 1'b0;
        wait_done("loop_pass3");
        tick(1);
        check("loop_stop_held", bus.done, 1);
        check("loop_q0", q0.size(), 0);
        check("loop_q1", q1.size(), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
